// File: rtl/display_value_arbiter_pkg.sv
// DigitType: shared display types for the seven-segment path.
//   digit_t     one BCD digit
//   digits_t    the full 8-digit display word, [7] = leftmost (AN7)
//   state_t     arbiter/converter FSM states
//   lz_enable   per-digit enable mask for leading-zero blanking
package DigitType;
  typedef logic [3:0] digit_t;

  localparam int DISP_DIGITS = 8;
  localparam int BCD_MAX     = 99_999_999;

  typedef digit_t [DISP_DIGITS-1:0] digits_t;

  typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

  // A digit is lit if it or any more significant digit is non-zero.
  // Digit 0 is always lit, so a zero value still shows "0".
  function automatic logic [DISP_DIGITS-1:0] lz_enable(digits_t d);
    logic seen;
    lz_enable = '0;
    seen      = 1'b0;
    for (int i = DISP_DIGITS-1; i >= 0; i--) begin
      seen         = seen | (d[i] != 4'd0);
      lz_enable[i] = seen | (i == 0);
    end
  endfunction
endpackage

// File: rtl/display_value_arbiter_dabble_step.sv
// dabble_step: one combinational double-dabble iteration.
//   bcd_in   current 8-digit BCD accumulator
//   bit_in   next binary bit, MSB first
//   bcd_out  accumulator after add-3 correction and a 1-bit left shift
module dabble_step
  import DigitType::*;
(
  input  digits_t bcd_in,
  input  logic    bit_in,
  output digits_t bcd_out
);
  digits_t                      adj;
  logic [4*DISP_DIGITS-1:0]     adj_f;

  for (genvar i = 0; i < DISP_DIGITS; i++) begin : g_nib
    assign adj[i] = (bcd_in[i] >= 4'd5) ? bcd_in[i] + 4'd3 : bcd_in[i];
  end

  assign adj_f   = adj;
  assign bcd_out = {adj_f[4*DISP_DIGITS-2:0], bit_in};
endmodule

// File: rtl/display_value_arbiter.sv
// display_value_arbiter: round-robin share of the 8-digit display.
//   clk, rst          system clock, async active-high reset
//   req_valid/value/  per-requester request (value is unsigned binary,
//   req_blank_lz      blank_lz enables leading-zero blanking)
//   req_ready         one-hot accept, only in IDLE
//   digits, en        registered BCD digits and per-digit enables
//   busy              high from accept until the result is committed
//   overflow          last accepted value did not fit in 8 digits
module display_value_arbiter
  import DigitType::*;
#(
  parameter int N_REQ = 2,
  parameter int WIDTH = 27
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_value,
  input  logic [N_REQ-1:0]            req_blank_lz,
  output logic [N_REQ-1:0]            req_ready,
  output digits_t                     digits,
  output logic [DISP_DIGITS-1:0]      en,
  output logic                        busy,
  output logic                        overflow
);
  localparam int GW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(WIDTH + 1);

  state_t            state;
  logic [GW-1:0]     last_grant, grant_idx, cand;
  logic              found;
  logic [WIDTH-1:0]  val_lat, val_sh;
  logic              blank_lat;
  digits_t           bcd, bcd_nxt;
  logic [CW-1:0]     cnt;
  logic              val_ovf;

  dabble_step u_step (
    .bcd_in  (bcd),
    .bit_in  (val_sh[WIDTH-1]),
    .bcd_out (bcd_nxt)
  );

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found     = 1'b0;
    grant_idx = last_grant;
    cand      = '0;
    req_ready = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand = GW'((int'(last_grant) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    // Gated by rst so ready reads zero while reset is held.
    if (state == IDLE && found && !rst) req_ready[grant_idx] = 1'b1;
  end

  // Overflow is judged on the original value; the BCD result is garbage then.
  assign val_ovf = 32'(val_lat) > 32'(BCD_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GW'(N_REQ - 1);
      val_lat    <= '0;
      val_sh     <= '0;
      blank_lat  <= 1'b0;
      bcd        <= '0;
      cnt        <= '0;
      digits     <= '0;
      en         <= '0;
      busy       <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            val_lat    <= req_value[grant_idx];
            val_sh     <= req_value[grant_idx];
            blank_lat  <= req_blank_lz[grant_idx];
            last_grant <= grant_idx;
            bcd        <= '0;
            cnt        <= CW'(WIDTH);
            busy       <= 1'b1;
            state      <= CONVERT;
          end
        end
        CONVERT: begin
          bcd    <= bcd_nxt;
          val_sh <= val_sh << 1;
          cnt    <= cnt - 1'b1;
          if (cnt == CW'(1)) state <= COMMIT;
        end
        COMMIT: begin
          if (val_ovf) begin
            overflow <= 1'b1;
            digits   <= '0;
            en       <= '0;
          end else begin
            overflow <= 1'b0;
            digits   <= bcd;
            en       <= blank_lat ? lz_enable(bcd) : '1;
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_display_value_arbiter.sv
module tb_display_value_arbiter;
  import DigitType::*;

  localparam int N_REQ = 2;
  localparam int WIDTH = 27;

  logic                        clk = 1'b0;
  logic                        rst;
  logic [N_REQ-1:0]            req_valid;
  logic [N_REQ-1:0][WIDTH-1:0] req_value;
  logic [N_REQ-1:0]            req_blank_lz;
  logic [N_REQ-1:0]            req_ready;
  digits_t                     digits;
  logic [7:0]                  en;
  logic                        busy;
  logic                        overflow;

  always #5 clk = ~clk;

  display_value_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_value    (req_value),
    .req_blank_lz (req_blank_lz),
    .req_ready    (req_ready),
    .digits       (digits),
    .en           (en),
    .busy         (busy),
    .overflow     (overflow)
  );

  typedef struct {
    logic [31:0] d;
    logic [7:0]  en;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;
  int   rr_last = N_REQ - 1;

  task automatic check(string name, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Reference: decimal digits by division, enable mask from digit count.
  function automatic exp_t model(longint v, logic blank);
    exp_t   e;
    int     nd;
    longint t;
    e.d = '0; e.en = '0; e.ovf = 1'b0;
    if (v > 64'd99999999) begin
      e.ovf = 1'b1;
      return e;
    end
    t = v;
    for (int i = 0; i < 8; i++) begin
      e.d[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    nd = 1;
    t  = v / 10;
    while (t > 0) begin nd++; t = t / 10; end
    e.en = blank ? 8'((1 << nd) - 1) : 8'hFF;
    return e;
  endfunction

  task automatic send(int r, logic [WIDTH-1:0] v, logic b);
    int n;
    bit got;
    n = 0; got = 0;
    @(posedge clk); #1;
    req_valid[r]    = 1'b1;
    req_value[r]    = v;
    req_blank_lz[r] = b;
    while (!got && n < 400) begin
      @(negedge clk);
      if (req_ready[r]) got = 1;
      n++;
    end
    if (!got) begin
      checks++;
      $display("FAIL send_timeout: req%0d never accepted, required accept within 400 cycles", r);
      req_valid[r] = 1'b0;
      return;
    end
    sb.push_back(model(longint'(v), b));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    req_value[r] = WIDTH'($urandom);  // must not disturb the conversion
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      $display("FAIL idle_timeout: pending %0d busy %0b, required 0/0", sb.size(), busy);
    end
  endtask

  // Result monitor: compare on each commit (busy falling).
  initial begin
    bit   prev_busy;
    int   bcnt;
    exp_t e;
    prev_busy = 0; bcnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_busy = 0;
        bcnt      = 0;
      end else begin
        if (busy) bcnt++;
        if (prev_busy && !busy) begin
          if (sb.size() == 0) begin
            checks++;
            $display("FAIL unexpected_commit: digits %0h with no pending request", digits);
          end else begin
            e = sb.pop_front();
            check("digits",      digits,   e.d);
            check("en",          en,       e.en);
            check("overflow",    overflow, e.ovf);
            check("busy_cycles", bcnt,     WIDTH + 1);
          end
          bcnt = 0;
        end
        prev_busy = busy;
      end
    end
  end

  // Grant monitor: round-robin winner from a simple rotating pointer.
  initial begin
    int w, c;
    forever begin
      @(negedge clk);
      if (rst) rr_last = N_REQ - 1;
      else if (busy) check("ready_while_busy", req_ready, 0);
      else if (req_valid == '0) check("ready_no_valid", req_ready, 0);
      else begin
        w = -1;
        for (int k = 1; k <= N_REQ; k++) begin
          c = (rr_last + k) % N_REQ;
          if (w < 0 && req_valid[c]) w = c;
        end
        check("rr_grant", req_ready, 64'(1) << w);
        rr_last = w;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [WIDTH-1:0] v0, v1;
    logic             b0, b1;
    rst = 1'b1; req_valid = '0; req_value = '0; req_blank_lz = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_digits",   digits,    0);
    check("rst_en",       en,        0);
    check("rst_busy",     busy,      0);
    check("rst_overflow", overflow,  0);
    check("rst_ready",    req_ready, 0);
    rst = 1'b0;

    send(0, 27'd12345, 1'b1);      wait_idle();
    send(0, 27'd0, 1'b1);          wait_idle();
    send(0, 27'd99999999, 1'b1);   wait_idle();
    send(1, 27'd100000000, 1'b1);  wait_idle();
    send(1, 27'd42, 1'b0);         wait_idle();

    fork
      begin send(0, 27'd11, 1'b1); send(0, 27'd11, 1'b1); send(0, 27'd11, 1'b1); end
      begin send(1, 27'd22, 1'b1); send(1, 27'd22, 1'b1); send(1, 27'd22, 1'b1); end
    join
    wait_idle();

    for (int it = 0; it < 20; it++) begin
      case ($urandom_range(0, 3))
        0:       v0 = WIDTH'($urandom);
        1:       v0 = WIDTH'($urandom_range(0, 999));
        2:       v0 = WIDTH'(99999990 + $urandom_range(0, 20));
        default: v0 = WIDTH'($urandom_range(0, 99999999));
      endcase
      v1 = WIDTH'($urandom_range(0, 134217727));
      b0 = 1'($urandom_range(0, 1));
      b1 = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) begin
        fork
          send(0, v0, b0);
          send(1, v1, b1);
        join
      end else begin
        send($urandom_range(0, 1), v0, b0);
      end
      wait_idle();
    end

    // Reset 10 cycles into a conversion.
    send(0, 27'd555, 1'b1);
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("midrst_digits",   digits,    0);
    check("midrst_en",       en,        0);
    check("midrst_busy",     busy,      0);
    check("midrst_overflow", overflow,  0);
    check("midrst_ready",    req_ready, 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(1, 27'd7, 1'b1);
    wait_idle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule

// File: doc/display_value_arbiter.md
# display_value_arbiter

Shares the 8-digit seven-segment display between several requesters that each want to show an unsigned binary value. Requests are granted round-robin over a valid/ready handshake. The granted value is converted to eight BCD digits by an iterative shift-and-add-3 (double-dabble) engine, and optional leading-zero blanking is applied. The block drives the `digits`/`en` inputs of `SevenSegDigits` from the system clock domain.

## Interface
- `N_REQ`, default 2, number of requesters (2..4).
- `WIDTH`, default 27, bit width of each request value (≤ 27).
- `clk`  in  1  system clock; one clock domain only.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_value`  in  N_REQ×WIDTH  packed array; unsigned binary value per requester.
- `req_blank_lz`  in  N_REQ  per-requester leading-zero blanking enable.
- `req_ready`  out  N_REQ  one-hot accept; a transfer occurs when `req_valid[g]` and `req_ready[g]` are both high at a clock edge.
- `digits`  out  8×digit_t  BCD digits; `digits[7]` is most significant (leftmost, AN7).
- `en`  out  8  per-digit enable for the display.
- `busy`  out  1  high while a conversion is in flight.
- `overflow`  out  1  set when the last accepted value exceeds 99_999_999.

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
- **IDLE**
  - If any `req_valid` is high, combinationally raise `req_ready` for the round-robin winner only.
  - Search starts at `last_grant+1` and wraps modulo N_REQ.
  - On transfer: latch value and blank flag, update `last_grant`, clear the BCD accumulator, load the iteration counter with WIDTH, go to CONVERT.
- **CONVERT**, one iteration per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then shift {BCD[31:0], value} left by 1.
  - Decrement the counter; at 0, go to COMMIT.
- **COMMIT**, one cycle, then return to IDLE:
  - If latched value ≥ 100_000_000: `overflow`=1, `digits`=all 0, `en`=8'h00.
  - Else: `overflow`=0, `digits`=BCD result.
  - `en` with blank flag set: bit i = 1 iff i=0 or some `digits[j]`≠0 for j≥i. Value 0 therefore shows a single "0".
  - `en` with blank flag clear: 8'hFF.
- `req_ready` is all-zero in CONVERT and COMMIT. Requests are never dropped; a requester holds `req_valid` until it is accepted.
- `req_value` is sampled only on the accept edge; later changes do not affect the conversion in flight.
- `digits`, `en` and `overflow` are registered and hold their values between commits.
- Reset values:
  - State IDLE.
  - `digits` all 0, `en` 8'h00 (display dark).
  - `busy` 0, `overflow` 0, `req_ready` 0.
  - `last_grant`=N_REQ−1, so requester 0 wins first.
- Reset asserted mid-CONVERT or mid-COMMIT: abort immediately (asynchronous), all outputs go to reset values, and the in-flight request is lost.

## Timing
- Accept at edge A.
- CONVERT occupies edges A+1..A+WIDTH.
- Outputs update at edge A+WIDTH+1 (28 cycles for WIDTH=27).
- `busy` rises at edge A and falls at edge A+WIDTH+1, together with the output update.
- Earliest next accept is edge A+WIDTH+2, giving a throughput of one value per WIDTH+2 cycles.
- `req_ready` depends combinationally on `req_valid` and state only; there is no path from `req_value`.
- Simultaneous valids: exactly one grant per IDLE cycle, fairness strictly alternating for N_REQ=2.

## Structure
- Shared package `DigitType`:
  - existing `digit_t`;
  - add `DISP_DIGITS`=8;
  - add `BCD_MAX`=99_999_999;
  - add a `digits_t` typedef (8×digit_t).
- One combinational sub-module, `dabble_step`: inputs 32-bit BCD plus 1 incoming bit, output the next 32-bit BCD (add-3 then shift). It is instantiated once in CONVERT.
- The round-robin arbiter and FSM stay inline.

## Test plan
- **Single request:** after reset, req0 = 12345, blank_lz = 1.
  - Outputs after 28 cycles: `digits[7..0]` = 0,0,0,1,2,3,4,5; `en` = 8'h1F; `overflow` = 0.
  - `busy` high for exactly 28 cycles.
- **Zero and boundary:**
  - Value 0 with blank_lz = 1 → `en` = 8'h01, `digits` all 0.
  - Value 99_999_999 → all 9s, `en` = 8'hFF.
  - Value 100_000_000 → `overflow` = 1, `en` = 8'h00.
- **No blanking:** req1 = 42, blank_lz = 0 → `digits` = 0,0,0,0,0,0,4,2; `en` = 8'hFF.
- **Arbitration:** req0 and req1 held valid continuously with values 11 and 22.
  - Grants alternate 0,1,0,1 and the display alternates 11/22.
  - `req_ready` is one-hot and never high while `busy`.
  - `req_value` changed after accept has no effect.
- **Reset mid-operation:** assert `rst` 10 cycles into CONVERT.
  - Outputs immediately return to reset values.
  - After release, req1 = 7 converts correctly to `en` = 8'h01, `digits[0]` = 7.
